// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes, functs, ALU and mux select codes.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JAL       = 4'd11,
    S_JR        = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  localparam logic [5:0] ALUOP_AND = 6'd0;
  localparam logic [5:0] ALUOP_OR  = 6'd1;
  localparam logic [5:0] ALUOP_ADD = 6'd2;
  localparam logic [5:0] ALUOP_SUB = 6'd6;
  localparam logic [5:0] ALUOP_SLT = 6'd7;
  localparam logic [5:0] ALUOP_NOR = 6'd12;

  localparam logic [1:0] EXT_LOGIC = 2'b00;
  localparam logic [1:0] EXT_ARITH = 2'b01;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RD = 2'b00;
  localparam logic [1:0] RDST_RT = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  typedef struct packed {
    logic       cpu_mio;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic [1:0] ext_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mips_mc_funct_decode.sv
// Combinational R-type funct decode: recognised flag, ALU operation, jr/jalr detection.
module mips_mc_funct_decode
  import mips_multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic       legal,
  output logic [5:0] alu_op,
  output logic       is_jr,
  output logic       is_jalr
);

  always_comb begin
    legal   = 1'b1;
    alu_op  = ALUOP_AND;
    is_jr   = 1'b0;
    is_jalr = 1'b0;
    case (funct)
      FUNCT_ADD:  alu_op = ALUOP_ADD;
      FUNCT_SUB:  alu_op = ALUOP_SUB;
      FUNCT_AND:  alu_op = ALUOP_AND;
      FUNCT_OR:   alu_op = ALUOP_OR;
      FUNCT_NOR:  alu_op = ALUOP_NOR;
      FUNCT_SLT:  alu_op = ALUOP_SLT;
      FUNCT_JR:   is_jr = 1'b1;
      FUNCT_JALR: is_jalr = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction, stalls on MIO_ready with a bounded wait.
// jal/jr/jalr support is added when MIPS_MC_LINK_EN is defined.
module mips_multicycle_control #(
  parameter int ALUOP_W     = 6,
  parameter int TIMEOUT_W   = 4,
  parameter int MIO_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               MIO_ready,
  output logic               CPU_MIO,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         EXTOp,
  output logic [1:0]         PCSource,
  output logic [3:0]         state_o,
  output logic               bus_err,
  output logic               illegal
);
  import mips_multicycle_control_pkg::*;

  state_t               state, state_nxt;
  ctrl_t                c;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 store_q;
  logic                 dec_illegal;
  logic                 timeout;
  logic                 fd_legal, fd_jr, fd_jalr;
  logic [5:0]           fd_alu_op;
`ifdef MIPS_MC_LINK_EN
  logic                 jalr_q;
`endif

  mips_mc_funct_decode u_funct_decode (
    .funct   (Funct),
    .legal   (fd_legal),
    .alu_op  (fd_alu_op),
    .is_jr   (fd_jr),
    .is_jalr (fd_jalr)
  );

  assign timeout = is_wait_state(state) && !MIO_ready &&
                   (wait_cnt == TIMEOUT_W'(MIO_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // Counter only runs across consecutive stalled cycles, so any wait-state entry sees zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      store_q  <= 1'b0;
      bus_err  <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (is_wait_state(state) && !MIO_ready && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                                 wait_cnt <= '0;
      if (state == S_DECODE) store_q <= (Op == OP_SW);
      bus_err <= timeout;
      illegal <= dec_illegal;
    end
  end

`ifdef MIPS_MC_LINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    jalr_q <= 1'b0;
    else if (state == S_DECODE) jalr_q <= fd_jalr;
  end
`endif

  always_comb begin
    state_nxt   = state;
    c           = '0;
    dec_illegal = 1'b0;
    case (state)
      S_INIT: state_nxt = S_FETCH;
      S_FETCH: begin
        c.cpu_mio   = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        if (MIO_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
        c.ext_op    = EXT_ARITH;
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_RTYPE: begin
            if (fd_legal && !fd_jr && !fd_jalr) state_nxt = S_R_EXEC;
`ifdef MIPS_MC_LINK_EN
            else if (fd_jr || fd_jalr) state_nxt = S_JR;
`endif
            else begin
              state_nxt   = S_FETCH;
              dec_illegal = 1'b1;
            end
          end
          OP_BEQ: state_nxt = S_BRANCH;
          OP_J:   state_nxt = S_JUMP;
`ifdef MIPS_MC_LINK_EN
          OP_JAL: state_nxt = S_JAL;
`endif
          default: begin
            state_nxt   = S_FETCH;
            dec_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
        c.ext_op    = EXT_ARITH;
        state_nxt   = store_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        c.cpu_mio  = 1'b1;
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        if (MIO_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RT;
        c.mem_to_reg = M2R_MDR;
        state_nxt    = S_FETCH;
      end
      S_MEM_WRITE: begin
        c.cpu_mio   = 1'b1;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        if (MIO_ready) state_nxt = S_FETCH;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.ext_op    = EXT_LOGIC;
        c.alu_op    = fd_alu_op;
        state_nxt   = S_R_WB;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RD;
        c.mem_to_reg = M2R_ALUOUT;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        state_nxt       = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
        state_nxt   = S_FETCH;
      end
`ifdef MIPS_MC_LINK_EN
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RA;
        c.mem_to_reg = M2R_PC;
        state_nxt    = S_FETCH;
      end
      S_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_RS;
        if (jalr_q) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = RDST_RD;
          c.mem_to_reg = M2R_PC;
        end
        state_nxt = S_FETCH;
      end
`endif
      default: state_nxt = S_INIT;
    endcase
    // An expired wait suppresses every strobe so the aborted transfer leaves no side effects.
    if (timeout) begin
      c         = '0;
      state_nxt = S_FETCH;
    end
  end

  assign CPU_MIO     = c.cpu_mio;
  assign PCWrite     = c.pc_write;
  assign PCWriteCond = c.pc_write_cond;
  assign IorD        = c.i_or_d;
  assign MemRead     = c.mem_read;
  assign MemWrite    = c.mem_write;
  assign IRWrite     = c.ir_write;
  assign MemtoReg    = c.mem_to_reg;
  assign RegDst      = c.reg_dst;
  assign RegWrite    = c.reg_write;
  assign ALUSrcA     = c.alu_src_a;
  assign ALUSrcB     = c.alu_src_b;
  assign ALUOp       = ALUOP_W'(c.alu_op);
  assign EXTOp       = c.ext_op;
  assign PCSource    = c.pc_source;
  assign state_o     = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: stimulus pushes hand-derived per-cycle control vectors, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mips_multicycle_control;
  import mips_multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = '0, Funct = '0;
  logic       MIO_ready = 1'b0;
  logic       CPU_MIO, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] MemtoReg, RegDst, ALUSrcB, EXTOp, PCSource;
  logic [5:0] ALUOp;
  logic [3:0] state_o;
  logic       bus_err, illegal;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .MIO_ready(MIO_ready),
    .CPU_MIO(CPU_MIO), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .EXTOp(EXTOp), .PCSource(PCSource), .state_o(state_o),
    .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       cpu_mio, pcw, pcwc, iord, mrd, mwr, irw;
    logic [1:0] m2r, rdst;
    logic       rw, srca;
    logic [1:0] srcb;
    logic [5:0] aluop;
    logic [1:0] ext, pcsrc;
    logic       berr, ill;
  } obs_t;

  obs_t  act;
  obs_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  always_comb begin
    act       = '0;
    act.st    = state_o;  act.cpu_mio = CPU_MIO; act.pcw  = PCWrite;  act.pcwc = PCWriteCond;
    act.iord  = IorD;     act.mrd     = MemRead; act.mwr  = MemWrite; act.irw  = IRWrite;
    act.m2r   = MemtoReg; act.rdst    = RegDst;  act.rw   = RegWrite; act.srca = ALUSrcA;
    act.srcb  = ALUSrcB;  act.aluop   = ALUOp;   act.ext  = EXTOp;    act.pcsrc = PCSource;
    act.berr  = bus_err;  act.ill     = illegal;
  end

  always @(negedge clk) begin
    obs_t  e;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %h required %h", n, act, e);
    end
  end

  // Expected vectors per state, written out from the control table.
  function automatic obs_t vz(input logic [3:0] st);
    obs_t v = '0;
    v.st = st;
    return v;
  endfunction
  function automatic obs_t v_fetch(input logic rdy);
    obs_t v = vz(S_FETCH);
    v.cpu_mio = 1; v.mrd = 1; v.srcb = 2'b01; v.aluop = 6'd2; v.irw = rdy; v.pcw = rdy;
    return v;
  endfunction
  function automatic obs_t v_decode();
    obs_t v = vz(S_DECODE);
    v.srcb = 2'b11; v.aluop = 6'd2; v.ext = 2'b01;
    return v;
  endfunction
  function automatic obs_t v_maddr();
    obs_t v = vz(S_MEM_ADDR);
    v.srca = 1; v.srcb = 2'b10; v.aluop = 6'd2; v.ext = 2'b01;
    return v;
  endfunction
  function automatic obs_t v_mread();
    obs_t v = vz(S_MEM_READ);
    v.cpu_mio = 1; v.mrd = 1; v.iord = 1;
    return v;
  endfunction
  function automatic obs_t v_mwb();
    obs_t v = vz(S_MEM_WB);
    v.rw = 1; v.rdst = 2'b01; v.m2r = 2'b01;
    return v;
  endfunction
  function automatic obs_t v_mwrite();
    obs_t v = vz(S_MEM_WRITE);
    v.cpu_mio = 1; v.mwr = 1; v.iord = 1;
    return v;
  endfunction
  function automatic obs_t v_rexec(input logic [5:0] aop);
    obs_t v = vz(S_R_EXEC);
    v.srca = 1; v.aluop = aop;
    return v;
  endfunction
  function automatic obs_t v_rwb();
    obs_t v = vz(S_R_WB);
    v.rw = 1;
    return v;
  endfunction
  function automatic obs_t v_branch();
    obs_t v = vz(S_BRANCH);
    v.srca = 1; v.aluop = 6'd6; v.pcwc = 1; v.pcsrc = 2'b01;
    return v;
  endfunction
  function automatic obs_t v_jump();
    obs_t v = vz(S_JUMP);
    v.pcw = 1; v.pcsrc = 2'b10;
    return v;
  endfunction
  function automatic obs_t with_ill(input obs_t v);
    obs_t r = v;
    r.ill = 1;
    return r;
  endfunction
  function automatic obs_t with_berr(input obs_t v);
    obs_t r = v;
    r.berr = 1;
    return r;
  endfunction

  task automatic step(input string n, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input obs_t e);
    Op = op; Funct = fn; MIO_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [5:0] aop_tab[5] = '{6'd6, 6'd0, 6'd1, 6'd12, 6'd7};

  initial begin
    @(posedge clk); #1;
    step("reset", 6'b0, 6'b0, 0, vz(S_INIT));
    rst = 0;
    step("init", 6'b0, 6'b0, 1, vz(S_INIT));

    // add: 4 cycles
    step("add_fetch", 6'b000000, 6'b100000, 1, v_fetch(1));
    step("add_dec",   6'b000000, 6'b100000, 1, v_decode());
    step("add_exec",  6'b000000, 6'b100000, 1, v_rexec(6'd2));
    step("add_wb",    6'b000000, 6'b100000, 1, v_rwb());

    for (int i = 0; i < 5; i++) begin
      step("r_fetch", 6'b000000, fn_tab[i], 1, v_fetch(1));
      step("r_dec",   6'b000000, fn_tab[i], 1, v_decode());
      step("r_exec",  6'b000000, fn_tab[i], 1, v_rexec(aop_tab[i]));
      step("r_wb",    6'b000000, fn_tab[i], 1, v_rwb());
    end

    // lw with three stalled read cycles; Op changes after DECODE must be ignored
    step("lw_fetch", 6'b100011, 6'b0, 1, v_fetch(1));
    step("lw_dec",   6'b100011, 6'b0, 1, v_decode());
    step("lw_addr",  6'b101011, 6'b0, 1, v_maddr());
    for (int i = 0; i < 3; i++) step("lw_stall", 6'b101011, 6'b0, 0, v_mread());
    step("lw_read",  6'b101011, 6'b0, 1, v_mread());
    step("lw_wb",    6'b101011, 6'b0, 1, v_mwb());

    step("sw_fetch", 6'b101011, 6'b0, 1, v_fetch(1));
    step("sw_dec",   6'b101011, 6'b0, 1, v_decode());
    step("sw_addr",  6'b100011, 6'b0, 1, v_maddr());
    step("sw_stall", 6'b100011, 6'b0, 0, v_mwrite());
    step("sw_write", 6'b100011, 6'b0, 1, v_mwrite());

    step("beq_fetch", 6'b000100, 6'b0, 1, v_fetch(1));
    step("beq_dec",   6'b000100, 6'b0, 1, v_decode());
    step("beq_br",    6'b000100, 6'b0, 1, v_branch());
    step("j_fetch",   6'b000010, 6'b0, 1, v_fetch(1));
    step("j_dec",     6'b000010, 6'b0, 1, v_decode());
    step("j_jump",    6'b000010, 6'b0, 1, v_jump());

    // undecoded opcode, then undecoded funct
    step("ill_fetch", 6'b111111, 6'b0, 1, v_fetch(1));
    step("ill_dec",   6'b111111, 6'b0, 1, v_decode());
    step("ill_pulse", 6'b000000, 6'b000000, 0, with_ill(v_fetch(0)));
    step("illf_fetch", 6'b000000, 6'b000000, 1, v_fetch(1));
    step("illf_dec",   6'b000000, 6'b000000, 1, v_decode());
    step("illf_pulse", 6'b000011, 6'b0, 1, with_ill(v_fetch(1)));

    // jal, link build or not
    step("jal_dec", 6'b000011, 6'b0, 1, v_decode());
`ifdef MIPS_MC_LINK_EN
    begin
      obs_t v;
      v = vz(S_JAL); v.pcw = 1; v.pcsrc = 2'b10; v.rw = 1; v.rdst = 2'b10; v.m2r = 2'b10;
      step("jal_exec", 6'b000011, 6'b0, 1, v);
      step("jalr_fetch", 6'b000000, 6'b001001, 1, v_fetch(1));
      step("jalr_dec",   6'b000000, 6'b001001, 1, v_decode());
      v = vz(S_JR); v.pcw = 1; v.pcsrc = 2'b11; v.rw = 1; v.m2r = 2'b10;
      step("jalr_exec",  6'b000000, 6'b000000, 1, v);
      step("jr_fetch", 6'b000000, 6'b001000, 1, v_fetch(1));
      step("jr_dec",   6'b000000, 6'b001000, 1, v_decode());
      v = vz(S_JR); v.pcw = 1; v.pcsrc = 2'b11;
      step("jr_exec",  6'b000000, 6'b001000, 0, v);
    end
`else
    step("jal_illegal", 6'b000000, 6'b0, 0, with_ill(v_fetch(0)));
`endif

    // FETCH timeout: first step above stalled once, so restart the count via a fresh entry
    step("to_pre", 6'b000010, 6'b0, 1, v_fetch(1));
    step("to_dec", 6'b000010, 6'b0, 1, v_decode());
    step("to_jump", 6'b000010, 6'b0, 0, v_jump());
    for (int i = 0; i < 15; i++) step("to_stall", 6'b000010, 6'b0, 0, v_fetch(0));
    step("to_abort", 6'b000010, 6'b0, 0, vz(S_FETCH));
    step("to_berr",  6'b000010, 6'b0, 0, with_berr(v_fetch(0)));
    for (int i = 1; i < 15; i++) step("to_restall", 6'b000010, 6'b0, 0, v_fetch(0));
    step("to_edge_ok", 6'b000010, 6'b0, 1, v_fetch(1));
    step("to_edge_dec", 6'b100011, 6'b0, 1, v_decode());

    // reset in the middle of a load read
    step("rm_addr",  6'b100011, 6'b0, 0, v_maddr());
    step("rm_stall", 6'b100011, 6'b0, 0, v_mread());
    rst = 1;
    step("rm_reset", 6'b100011, 6'b0, 1, vz(S_INIT));
    rst = 0;
    step("rm_init",  6'b100011, 6'b0, 1, vz(S_INIT));
    step("rm_fetch", 6'b100011, 6'b0, 0, v_fetch(0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries unchecked, required 0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
